// File: rtl/mssd_param.sv
// Serial frame demultiplexer: start bit, dest/length header, payload steered to p[dest], stop bit.
// Define MSSD_PARITY_EN to add an even-parity bit between payload and stop bit.
module mssd_param #(
  parameter  int N_CH   = 4,
  parameter  int LEN_W  = 6,
  localparam int DEST_W = $clog2(N_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              serIn,
  output logic [N_CH-1:0]   p,
  output logic [DEST_W-1:0] dest,
  output logic              busy,
  output logic              outvalid,
  output logic              error
);

  localparam int HDR_W = DEST_W + LEN_W;
  localparam int CNT_W = $clog2(HDR_W);

  typedef enum logic [2:0] {
    IDLE, HDR, XMIT, STOP, ERR
`ifdef MSSD_PARITY_EN
    , PAR
`endif
  } state_t;

`ifdef MSSD_PARITY_EN
  localparam state_t AFTER_PAY = PAR;
`else
  localparam state_t AFTER_PAY = STOP;
`endif

  state_t            state_q, state_d;
  logic [HDR_W-1:0]  hdr_q, hdr_d, hdr_full;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [DEST_W-1:0] dest_q, dest_d;
  logic [N_CH-1:0]   p_q, p_d;
  logic              outvalid_q, outvalid_d;
`ifdef MSSD_PARITY_EN
  logic              par_q, par_d;
`endif

  always_comb begin
    state_d    = state_q;
    hdr_d      = hdr_q;
    bit_cnt_d  = bit_cnt_q;
    len_d      = len_q;
    dest_d     = dest_q;
    p_d        = '0;
    outvalid_d = 1'b0;
    hdr_full   = {hdr_q[HDR_W-2:0], serIn};
`ifdef MSSD_PARITY_EN
    par_d      = par_q;
`endif
    case (state_q)
      IDLE: begin
        if (!serIn) begin
          state_d   = HDR;
          bit_cnt_d = '0;
`ifdef MSSD_PARITY_EN
          par_d     = 1'b0;
`endif
        end
      end
      HDR: begin
        hdr_d     = hdr_full;
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
        if (bit_cnt_q == CNT_W'(HDR_W - 1)) begin
          bit_cnt_d = '0;
          dest_d    = hdr_full[HDR_W-1 -: DEST_W];
          len_d     = hdr_full[LEN_W-1:0];
          state_d   = (hdr_full[LEN_W-1:0] != '0) ? XMIT : AFTER_PAY;
        end
      end
      XMIT: begin
        // Payload bit appears on its channel the cycle after it is sampled.
        p_d[dest_q] = serIn;
        len_d       = len_q - LEN_W'(1);
`ifdef MSSD_PARITY_EN
        par_d       = par_q ^ serIn;
`endif
        if (len_q == LEN_W'(1)) state_d = AFTER_PAY;
      end
`ifdef MSSD_PARITY_EN
      PAR: state_d = (par_q ^ serIn) ? ERR : STOP;
`endif
      STOP: begin
        if (serIn) begin
          state_d    = IDLE;
          outvalid_d = 1'b1;
        end else begin
          state_d = ERR;
        end
      end
      ERR: if (serIn) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      hdr_q      <= '0;
      bit_cnt_q  <= '0;
      len_q      <= '0;
      dest_q     <= '0;
      p_q        <= '0;
      outvalid_q <= 1'b0;
`ifdef MSSD_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      hdr_q      <= hdr_d;
      bit_cnt_q  <= bit_cnt_d;
      len_q      <= len_d;
      dest_q     <= dest_d;
      p_q        <= p_d;
      outvalid_q <= outvalid_d;
`ifdef MSSD_PARITY_EN
      par_q      <= par_d;
`endif
    end
  end

  assign p        = p_q;
  assign dest     = dest_q;
  assign busy     = (state_q != IDLE);
  assign outvalid = outvalid_q;
  assign error    = (state_q == ERR);

endmodule
